viterbi_input_fifo: RTL

//  Parametrised input stage for the Viterbi decoder. Accepts coded packets of PAIRS 2-bit symbols over a valid/ready handshake.

---
 rtl/viterbi_input_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/viterbi_input_fifo.sv
// Input stage for the Viterbi decoder: packet FIFO in front of a holding register,
// with the held packet exposed both in parallel and as a serial stream of symbol pairs.
module viterbi_input_fifo #(
   parameter int PAIRS = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [2*PAIRS-1:0]           in_data,
   output logic                         in_ready,
   input  logic                         refresh,
   output logic [2*PAIRS-1:0]           pkt_data,
   output logic                         pkt_valid,
   output logic [1:0]                   sym_pair,
   output logic                         sym_valid,
   input  logic                         sym_ready,
   output logic                         sym_last,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   input  logic                         clear_ovf
);

   localparam int W  = 2*PAIRS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(PAIRS-1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [IW-1:0] idx;
   logic          done;
   logic [W-1:0]  shifted;

   logic push;
   logic load;
   logic pop;
   logic bypass;
   logic write;

   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign load     = !pkt_valid || refresh;
   assign pop      = load && (count != '0);
   // An empty FIFO feeding an empty/refreshing holder skips the queue entirely.
   assign bypass   = load && (count == '0) && push;
   assign write    = push && !bypass;

   always_ff @(posedge clk) begin
      if (write) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (write) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({write, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_data  <= '0;
         pkt_valid <= 1'b0;
      end else if (load) begin
         if (count != '0) begin
            pkt_data  <= mem[rd_ptr];
            pkt_valid <= 1'b1;
         end else if (push) begin
            pkt_data  <= in_data;
            pkt_valid <= 1'b1;
         end else begin
            pkt_valid <= 1'b0;
         end
      end
   end

   // Refresh is part of load, so it restarts the stream even over a same-edge handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         done <= 1'b0;
      end else if (load) begin
         idx  <= '0;
         done <= 1'b0;
      end else if (sym_valid && sym_ready) begin
         if (idx == LAST_IDX) done <= 1'b1;
         else                 idx  <= idx + IW'(1);
      end
   end

   assign shifted   = pkt_data << {idx, 1'b0};
   assign sym_pair  = shifted[W-1:W-2];
   assign sym_valid = pkt_valid && !done;
   assign sym_last  = sym_valid && (idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (in_valid && !in_ready) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule
